scene_draw_engine: RTL

SCENE_DRAW_ENGINE -- requirements
Module: scene_draw_engine

---
 rtl/scene_draw_engine.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/scene_draw_engine.sv
// rtl/scene_draw_engine.sv - rectangle raster engine for a bird-and-walls scene
// Erases the previous frame's objects, then draws the current ones, one pixel per accepted cycle.
module scene_draw_engine #(
  parameter int NUM_WALLS = 2,
  parameter int COORD_W   = 8,
  parameter int COLOUR_W  = 3,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int BIRD_X    = 8,
  parameter int BIRD_SZ   = 4,
  parameter int WALL_W    = 10,
  parameter int HOLE_H    = 50,
  parameter logic [COLOUR_W-1:0] BIRD_COL = 3'b010,
  parameter logic [COLOUR_W-1:0] WALL_COL = 3'b100,
  parameter logic [COLOUR_W-1:0] BG_COL   = 3'b111
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           frame_start,
  input  logic [COORD_W-1:0]             bird_y,
  input  logic [NUM_WALLS*COORD_W-1:0]   wall_x,
  input  logic [NUM_WALLS*COORD_W-1:0]   hole_y,
  input  logic                           plot_ready,
  input  logic                           collision_clr,
  output logic [COORD_W-1:0]             x_out,
  output logic [COORD_W-1:0]             y_out,
  output logic [COLOUR_W-1:0]            colour_out,
  output logic                           plot,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           collision
);

  localparam int CW1 = COORD_W + 1;
  localparam int IW  = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
  localparam logic [CW1-1:0] L_SW  = CW1'(SCREEN_W);
  localparam logic [CW1-1:0] L_SH  = CW1'(SCREEN_H);
  localparam logic [CW1-1:0] L_BX  = CW1'(BIRD_X);
  localparam logic [CW1-1:0] L_BSZ = CW1'(BIRD_SZ);
  localparam logic [CW1-1:0] L_WW  = CW1'(WALL_W);
  localparam logic [CW1-1:0] L_HH  = CW1'(HOLE_H);

  typedef enum logic [2:0] {
    IDLE, ERASE_BIRD, ERASE_TOP, ERASE_BOT, DRAW_BIRD, DRAW_TOP, DRAW_BOT, DONE
  } state_t;

  state_t                         state, nxt_state;
  logic [IW-1:0]                  idx, nxt_idx;
  logic                           load;
  logic                           eval_pend;
  logic                           prev_valid;
  logic [COORD_W-1:0]             cur_by, prev_by;
  logic [NUM_WALLS*COORD_W-1:0]   cur_wx, cur_hy, prev_wx, prev_hy;
  logic [COORD_W-1:0]             rx0, rx_last, ry_last;

  logic                           erase, bird_rect, rect_empty, hit;
  logic [COORD_W-1:0]             s_by, s_wx, s_hy, x_last, y_last;
  logic [CW1-1:0]                 rx, ry, rw, rh, cw, ch, hx, hh, hb;
  logic [COLOUR_W-1:0]            rcol;

  assign erase     = (state == ERASE_BIRD) || (state == ERASE_TOP) || (state == ERASE_BOT);
  assign bird_rect = (state == ERASE_BIRD) || (state == DRAW_BIRD);

  // Rectangle for the current state, clipped to the screen.
  always_comb begin
    s_by = erase ? prev_by : cur_by;
    s_wx = erase ? prev_wx[idx*COORD_W +: COORD_W] : cur_wx[idx*COORD_W +: COORD_W];
    s_hy = erase ? prev_hy[idx*COORD_W +: COORD_W] : cur_hy[idx*COORD_W +: COORD_W];
    rx = '0;
    ry = '0;
    rw = '0;
    rh = '0;
    case (state)
      ERASE_BIRD, DRAW_BIRD: begin
        rx = L_BX;
        ry = {1'b0, s_by};
        rw = L_BSZ;
        rh = L_BSZ;
      end
      ERASE_TOP, DRAW_TOP: begin
        rx = {1'b0, s_wx};
        rw = L_WW;
        rh = {1'b0, s_hy};
      end
      ERASE_BOT, DRAW_BOT: begin
        rx = {1'b0, s_wx};
        ry = {1'b0, s_hy} + L_HH;
        rw = L_WW;
        rh = (ry < L_SH) ? L_SH - ry : '0;
      end
      default: ;
    endcase
    cw = '0;
    ch = '0;
    if (rx < L_SW && ry < L_SH) begin
      cw = (rw < L_SW - rx) ? rw : L_SW - rx;
      ch = (rh < L_SH - ry) ? rh : L_SH - ry;
    end
    rect_empty = (cw == '0) || (ch == '0);
    x_last     = COORD_W'(rx + cw - 1'b1);
    y_last     = COORD_W'(ry + ch - 1'b1);
    rcol       = erase ? BG_COL : (bird_rect ? BIRD_COL : WALL_COL);
  end

  always_comb begin
    nxt_state = IDLE;
    nxt_idx   = '0;
    case (state)
      ERASE_BIRD: nxt_state = ERASE_TOP;
      ERASE_TOP: begin
        nxt_state = ERASE_BOT;
        nxt_idx   = idx;
      end
      ERASE_BOT: begin
        nxt_state = (idx == IW'(NUM_WALLS - 1)) ? DRAW_BIRD : ERASE_TOP;
        nxt_idx   = (idx == IW'(NUM_WALLS - 1)) ? '0 : idx + 1'b1;
      end
      DRAW_BIRD: nxt_state = DRAW_TOP;
      DRAW_TOP: begin
        nxt_state = DRAW_BOT;
        nxt_idx   = idx;
      end
      DRAW_BOT: begin
        nxt_state = (idx == IW'(NUM_WALLS - 1)) ? DONE : DRAW_TOP;
        nxt_idx   = (idx == IW'(NUM_WALLS - 1)) ? '0 : idx + 1'b1;
      end
      default: ;
    endcase
  end

  // Collision uses the unclipped bird against every wall's solid span.
  always_comb begin
    hit = ({1'b0, cur_by} + L_BSZ) > L_SH;
    hx  = '0;
    hh  = '0;
    hb  = {1'b0, cur_by};
    for (int i = 0; i < NUM_WALLS; i++) begin
      hx = {1'b0, cur_wx[i*COORD_W +: COORD_W]};
      hh = {1'b0, cur_hy[i*COORD_W +: COORD_W]};
      if ((L_BX < hx + L_WW) && (hx < L_BX + L_BSZ) &&
          ((hb < hh) || (hb + L_BSZ > hh + L_HH)))
        hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      idx        <= '0;
      load       <= 1'b0;
      eval_pend  <= 1'b0;
      prev_valid <= 1'b0;
      cur_by     <= '0;
      cur_wx     <= '0;
      cur_hy     <= '0;
      prev_by    <= '0;
      prev_wx    <= '0;
      prev_hy    <= '0;
      rx0        <= '0;
      rx_last    <= '0;
      ry_last    <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      collision  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      eval_pend  <= 1'b0;
      if (eval_pend)
        collision <= hit | (collision & ~collision_clr);
      else if (collision_clr)
        collision <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            cur_by    <= bird_y;
            cur_wx    <= wall_x;
            cur_hy    <= hole_y;
            busy      <= 1'b1;
            eval_pend <= 1'b1;
            load      <= 1'b1;
            idx       <= '0;
            state     <= prev_valid ? ERASE_BIRD : DRAW_BIRD;
          end
        end
        DONE: begin
          prev_by    <= cur_by;
          prev_wx    <= cur_wx;
          prev_hy    <= cur_hy;
          prev_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          if (load) begin
            if (rect_empty) begin
              state <= nxt_state;
              idx   <= nxt_idx;
              if (nxt_state == DONE) frame_done <= 1'b1;
            end else begin
              x_out      <= rx[COORD_W-1:0];
              y_out      <= ry[COORD_W-1:0];
              colour_out <= rcol;
              rx0        <= rx[COORD_W-1:0];
              rx_last    <= x_last;
              ry_last    <= y_last;
              plot       <= 1'b1;
              load       <= 1'b0;
            end
          end else if (plot_ready) begin
            if (x_out == rx_last) begin
              if (y_out == ry_last) begin
                plot  <= 1'b0;
                load  <= 1'b1;
                state <= nxt_state;
                idx   <= nxt_idx;
                if (nxt_state == DONE) frame_done <= 1'b1;
              end else begin
                x_out <= rx0;
                y_out <= y_out + 1'b1;
              end
            end else begin
              x_out <= x_out + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
